// File: rtl/adc_frame_buffer.sv
// Multi-channel ADC frame capture buffer: arm/capture into per-channel RAM,
// command-driven interleaved readout over valid/ready, and full-memory clear.

module adc_frame_buffer_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

module adc_frame_buffer #(
    parameter int          DATA_W   = 16,
    parameter int          CH       = 2,
    parameter int          DEPTH    = 1024,
    parameter logic [15:0] RD_CODE  = 16'h5A01,
    parameter logic [15:0] DEL_CODE = 16'h5A02,
    localparam int         AW       = $clog2(DEPTH),
    localparam int         CHW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic [AW:0]          frame_len,
    input  logic                 adc_valid,
    input  logic [CH*DATA_W-1:0] adc_data,
    input  logic                 cmd_valid,
    input  logic [15:0]          cmd,
    input  logic                 data_ready,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic [CHW-1:0]       data_ch,
    output logic                 data_last,
    output logic                 save_over,
    output logic                 busy,
    output logic                 cmd_err
);
    localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, CAPTURE, FULL, SND_RD, SND_LAT, SND_OUT, CLEAR} state_t;

    state_t                     state, nxt;
    logic   [AW-1:0]            wr_idx, rd_idx;
    logic   [CHW-1:0]           rd_ch;
    logic   [AW:0]              len;
    logic                       last_q;
    logic                       we, err_set;
    logic                       cmd_rd, cmd_del, in_send, cap_last, rd_last;
    logic   [CH-1:0][DATA_W-1:0] wdata, q;

    assign cmd_rd   = cmd_valid && (cmd == RD_CODE);
    assign cmd_del  = cmd_valid && (cmd == DEL_CODE);
    assign in_send  = (state == SND_RD) || (state == SND_LAT) || (state == SND_OUT);
    assign cap_last = ({1'b0, wr_idx} == (len - (AW+1)'(1)));
    assign rd_last  = ({1'b0, rd_idx} == (len - (AW+1)'(1))) && (rd_ch == CHW'(CH-1));

    assign data_valid = (state == SND_OUT);
    assign data_last  = last_q && data_valid;
    assign save_over  = (state == FULL) || in_send;
    assign busy       = !((state == IDLE) || (state == FULL));

    // One RAM per channel; clear shares the write port and address counter.
    for (genvar k = 0; k < CH; k++) begin : g_ch
        assign wdata[k] = (state == CLEAR) ? '0 : adc_data[k*DATA_W +: DATA_W];
        adc_frame_buffer_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
            .clk   (clk),
            .we    (we),
            .waddr (wr_idx),
            .wdata (wdata[k]),
            .raddr (rd_idx),
            .rdata (q[k])
        );
    end

    always_comb begin
        nxt     = state;
        we      = 1'b0;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                if (arm)          nxt = CAPTURE;
                else if (cmd_del) nxt = CLEAR;
                else if (cmd_rd)  err_set = 1'b1;
            end
            CAPTURE: begin
                if (cmd_rd || cmd_del || arm) err_set = 1'b1;
                if (adc_valid) begin
                    we = 1'b1;
                    if (cap_last) nxt = FULL;
                end
            end
            FULL: begin
                if (arm) err_set = 1'b1;
                if (cmd_rd)       nxt = SND_RD;
                else if (cmd_del) nxt = CLEAR;
            end
            SND_RD, SND_LAT, SND_OUT: begin
                if (arm || cmd_rd) err_set = 1'b1;
                if (state == SND_RD)       nxt = SND_LAT;
                else if (state == SND_LAT) nxt = SND_OUT;
                else if (data_ready)       nxt = rd_last ? FULL : SND_RD;
                if (cmd_del) nxt = CLEAR;
            end
            CLEAR: begin
                we = 1'b1;
                if (wr_idx == AW'(DEPTH-1)) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            wr_idx   <= '0;
            rd_idx   <= '0;
            rd_ch    <= '0;
            len      <= FULL_LEN;
            data_out <= '0;
            data_ch  <= '0;
            last_q   <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt == CLEAR && state != CLEAR) begin
                cmd_err <= 1'b0;
                wr_idx  <= '0;
            end else begin
                if (err_set) cmd_err <= 1'b1;
                if (we) wr_idx <= wr_idx + AW'(1);
                if (state == IDLE && arm) begin
                    len    <= (frame_len == '0 || frame_len > FULL_LEN) ? FULL_LEN : frame_len;
                    wr_idx <= '0;
                end
            end
            if (state == FULL && nxt == SND_RD) begin
                rd_idx <= '0;
                rd_ch  <= '0;
            end
            if (state == SND_LAT) begin
                data_out <= q[rd_ch];
                data_ch  <= rd_ch;
                last_q   <= rd_last;
            end
            // Advance to the next interleaved word only on a genuine acceptance.
            if (state == SND_OUT && data_ready && !cmd_del && !rd_last) begin
                if (rd_ch == CHW'(CH-1)) begin
                    rd_ch  <= '0;
                    rd_idx <= rd_idx + AW'(1);
                end else begin
                    rd_ch <= rd_ch + CHW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_adc_frame_buffer.sv
// Directed bench for adc_frame_buffer (CH=2, DEPTH=16): capture, readout,
// back-pressure, delete, default length, error flag and reset abort.

module tb_adc_frame_buffer;
    localparam logic [15:0] RD  = 16'h5A01;
    localparam logic [15:0] DEL = 16'h5A02;

    logic        clk = 0, rst = 0, arm = 0, adc_valid = 0, cmd_valid = 0, data_ready = 0;
    logic [4:0]  frame_len = 0;
    logic [31:0] adc_data = 0;
    logic [15:0] cmd = 0;
    logic [15:0] data_out;
    logic        data_valid, data_last, save_over, busy, cmd_err;
    logic [0:0]  data_ch;
    int          checks = 0, errors = 0;

    adc_frame_buffer #(.DATA_W(16), .CH(2), .DEPTH(16), .RD_CODE(RD), .DEL_CODE(DEL)) dut (
        .clk(clk), .rst(rst), .arm(arm), .frame_len(frame_len), .adc_valid(adc_valid),
        .adc_data(adc_data), .cmd_valid(cmd_valid), .cmd(cmd), .data_ready(data_ready),
        .data_out(data_out), .data_valid(data_valid), .data_ch(data_ch), .data_last(data_last),
        .save_over(save_over), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_arm(input logic [4:0] l);
        frame_len = l; arm = 1; tick(); arm = 0;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        adc_data = {b, a}; adc_valid = 1; tick(); adc_valid = 0;
    endtask

    task automatic send_cmd(input logic [15:0] c);
        cmd = c; cmd_valid = 1; tick(); cmd_valid = 0; cmd = 0;
    endtask

    // Waits (bounded) for a word, optionally stalls, then accepts it.
    task automatic read_word(input int stall, output logic [15:0] d, output logic c,
                             output logic l, output int gap, output logic stable);
        gap = 0;
        while (!data_valid && gap < 20) begin tick(); gap++; end
        d = data_out; c = data_ch[0]; l = data_last; stable = data_valid;
        data_ready = 0;
        repeat (stall) begin
            tick();
            if (!data_valid || data_out !== d || data_ch[0] !== c || data_last !== l) stable = 0;
        end
        data_ready = 1; tick(); data_ready = 0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
    endtask

    task automatic test_reset();
        rst = 0; tick(); tick();
        checks++; if (data_valid !== 0) begin errors++; $display("FAIL rst_valid got %b exp 0", data_valid); end
        checks++; if (data_out !== 0) begin errors++; $display("FAIL rst_data got %h exp 0", data_out); end
        checks++; if (data_last !== 0 || data_ch !== 0) begin errors++; $display("FAIL rst_last_ch got %b/%b exp 0/0", data_last, data_ch); end
        checks++; if (save_over !== 0 || busy !== 0 || cmd_err !== 0) begin errors++; $display("FAIL rst_flags got %b%b%b exp 000", save_over, busy, cmd_err); end
        rst = 1; tick();
    endtask

    task automatic test_capture();
        do_arm(4);
        checks++; if (busy !== 1) begin errors++; $display("FAIL cap_busy got %b exp 1", busy); end
        push(16'h11, 16'h21); push(16'h12, 16'h22); push(16'h13, 16'h23);
        checks++; if (save_over !== 0) begin errors++; $display("FAIL cap_early_save got %b exp 0", save_over); end
        push(16'h14, 16'h24);
        checks++; if (save_over !== 1) begin errors++; $display("FAIL cap_save got %b exp 1", save_over); end
        checks++; if (busy !== 0) begin errors++; $display("FAIL cap_busy_done got %b exp 0", busy); end
    endtask

    task automatic test_readout(input int stall_word);
        logic [15:0] d, e; logic c, l, st; int gap;
        send_cmd(16'h1234);
        checks++; if (cmd_err !== 0 || busy !== 0) begin errors++; $display("FAIL unk_cmd got err %b busy %b exp 0 0", cmd_err, busy); end
        send_cmd(RD);
        for (int k = 0; k < 8; k++) begin
            read_word((k == stall_word) ? 5 : 0, d, c, l, gap, st);
            e = 16'h11 + 16'(k / 2) + ((k % 2 == 1) ? 16'h10 : 16'h0);
            checks++; if (d !== e) begin errors++; $display("FAIL rd_data[%0d] got %h exp %h", k, d, e); end
            checks++; if (c !== 1'(k % 2)) begin errors++; $display("FAIL rd_ch[%0d] got %b exp %0d", k, c, k % 2); end
            checks++; if (l !== (k == 7)) begin errors++; $display("FAIL rd_last[%0d] got %b exp %b", k, l, k == 7); end
            checks++; if (gap !== 2) begin errors++; $display("FAIL rd_gap[%0d] got %0d exp 2", k, gap); end
            if (k == stall_word) begin
                checks++; if (st !== 1) begin errors++; $display("FAIL rd_stall_stable got %b exp 1", st); end
            end
        end
        checks++; if (busy !== 0 || save_over !== 1) begin errors++; $display("FAIL rd_done got busy %b save %b exp 0 1", busy, save_over); end
        checks++; if (cmd_err !== 0) begin errors++; $display("FAIL rd_err got %b exp 0", cmd_err); end
    endtask

    task automatic test_delete();
        logic [15:0] d; logic c, l, st; int gap, n;
        send_cmd(RD);
        for (int k = 0; k < 3; k++) read_word(0, d, c, l, gap, st);
        n = 0;
        while (!data_valid && n < 20) begin tick(); n++; end
        checks++; if (data_valid !== 1 || data_out !== 16'h22) begin errors++; $display("FAIL del_pending got v%b %h exp v1 0022", data_valid, data_out); end
        send_cmd(DEL);
        checks++; if (data_valid !== 0) begin errors++; $display("FAIL del_valid got %b exp 0", data_valid); end
        checks++; if (busy !== 1 || save_over !== 0) begin errors++; $display("FAIL del_flags got busy %b save %b exp 1 0", busy, save_over); end
        wait_idle(n);
        checks++; if (n !== 16) begin errors++; $display("FAIL del_cycles got %0d exp 16", n); end
        do_arm(1); push(16'hAA, 16'hBB);
        checks++; if (save_over !== 1) begin errors++; $display("FAIL len1_save got %b exp 1", save_over); end
        send_cmd(RD);
        read_word(0, d, c, l, gap, st);
        checks++; if (d !== 16'hAA || c !== 0 || l !== 0) begin errors++; $display("FAIL len1_w0 got %h ch%b last%b exp 00aa ch0 last0", d, c, l); end
        read_word(0, d, c, l, gap, st);
        checks++; if (d !== 16'hBB || c !== 1 || l !== 1) begin errors++; $display("FAIL len1_w1 got %h ch%b last%b exp 00bb ch1 last1", d, c, l); end
        checks++; if (busy !== 0) begin errors++; $display("FAIL len1_done got busy %b exp 0", busy); end
    endtask

    task automatic test_len0_err();
        logic [15:0] d, e; logic c, l, st; int gap, n;
        send_cmd(DEL); wait_idle(n);
        send_cmd(RD);
        checks++; if (cmd_err !== 1 || busy !== 0) begin errors++; $display("FAIL idle_rd got err %b busy %b exp 1 0", cmd_err, busy); end
        do_arm(0);
        for (int i = 0; i < 16; i++) begin
            arm = (i == 5);
            push(16'h100 + 16'(i), 16'h200 + 16'(i));
            arm = 0;
            if (i == 14) begin
                checks++; if (save_over !== 0) begin errors++; $display("FAIL len0_early got %b exp 0", save_over); end
            end
        end
        checks++; if (save_over !== 1 || cmd_err !== 1) begin errors++; $display("FAIL len0_full got save %b err %b exp 1 1", save_over, cmd_err); end
        send_cmd(RD);
        for (int k = 0; k < 32; k++) begin
            read_word(0, d, c, l, gap, st);
            e = ((k % 2 == 1) ? 16'h200 : 16'h100) + 16'(k / 2);
            checks++; if (d !== e || c !== 1'(k % 2) || l !== (k == 31)) begin
                errors++; $display("FAIL len0_w[%0d] got %h ch%b last%b exp %h ch%0d last%b", k, d, c, l, e, k % 2, k == 31); end
        end
        send_cmd(DEL);
        checks++; if (cmd_err !== 0 || save_over !== 0) begin errors++; $display("FAIL del_clr_err got err %b save %b exp 0 0", cmd_err, save_over); end
        wait_idle(n);
    endtask

    task automatic test_reset_mid();
        logic [15:0] d, e; logic c, l, st; int gap;
        do_arm(4); push(16'hA1, 16'hB1); push(16'hA2, 16'hB2);
        rst = 0; tick();
        checks++; if (busy !== 0 || save_over !== 0 || data_valid !== 0 || cmd_err !== 0) begin
            errors++; $display("FAIL rst_mid got busy %b save %b v %b err %b exp 0000", busy, save_over, data_valid, cmd_err); end
        rst = 1;
        do_arm(2); push(16'hC1, 16'hD1);
        checks++; if (save_over !== 0) begin errors++; $display("FAIL rst_re_early got %b exp 0", save_over); end
        push(16'hC2, 16'hD2);
        checks++; if (save_over !== 1) begin errors++; $display("FAIL rst_re_save got %b exp 1", save_over); end
        send_cmd(RD);
        for (int k = 0; k < 4; k++) begin
            read_word(0, d, c, l, gap, st);
            e = ((k % 2 == 1) ? 16'hD1 : 16'hC1) + 16'(k / 2);
            checks++; if (d !== e || l !== (k == 3)) begin errors++; $display("FAIL rst_re_w[%0d] got %h last%b exp %h last%b", k, d, l, e, k == 3); end
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_readout(-1);
        test_readout(2);
        test_readout(-1);
        test_delete();
        test_len0_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_frame_buffer.md
Name: adc_frame_buffer

Overview:
- Parametrised multi-channel ADC frame capture buffer with command-driven readout and clear.
- Captures a programmable number of samples per channel into internal block RAM when armed, then flags completion on save_over.
- Streams the frame out under a valid/ready handshake on a READ command.
- Wipes the memory on a DELETE command.
- Sits between the ADC sample front end and the host command/transmit path.

Parameters:
- DATA_W, 16, sample width per channel.
- CH, 2, number of ADC channels sampled together.
- DEPTH, 1024, samples per channel of storage; must be a power of two, at least 2.
- RD_CODE, 16'h5A01, command word that starts readout.
- DEL_CODE, 16'h5A02, command word that starts clear.

Derived widths:
- AW = clog2(DEPTH).
- CHW = max(1, clog2(CH)).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-low.
- arm  in  1  pulse; start a capture.
- frame_len  in  AW+1  samples per channel; latched on an accepted arm; 0 or >DEPTH means DEPTH.
- adc_valid  in  1  qualifies adc_data.
- adc_data  in  CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- cmd_valid  in  1  qualifies cmd.
- cmd  in  16  command word.
- data_ready  in  1  downstream accepts data_out.
- data_out  out  DATA_W  readout sample.
- data_valid  out  1  data_out valid; held until accepted.
- data_ch  out  CHW  channel index of data_out.
- data_last  out  1  final word of the frame.
- save_over  out  1  frame stored and readable.
- busy  out  1  high in every state except IDLE and FULL.
- cmd_err  out  1  sticky; command or arm rejected.

Behaviour:
- Reset: synchronous, active-low. Forces IDLE. All outputs are 0, all counters are 0, latched length is DEPTH.
  - RAM contents are not cleared by reset.
  - Reset in any state, including mid-SEND, aborts immediately. data_valid drops the next cycle.
- Storage: CH independent memories, each DEPTH x DATA_W, one write port and one synchronous read port with 1-cycle latency.
- States:
  - IDLE:
    - arm -> CAPTURE; latch len; wr_idx=0.
    - cmd==DEL_CODE -> CLEAR.
    - cmd==RD_CODE -> sets cmd_err; state unchanged.
  - CAPTURE:
    - Each adc_valid writes all CH channels at address wr_idx, then wr_idx+1.
    - Once the write at wr_idx==len-1 completes -> FULL; save_over=1 from the following cycle.
    - An adc_valid in the arm cycle itself is not stored.
    - Commands in CAPTURE set cmd_err and are ignored.
  - FULL:
    - RD_CODE -> SEND; rd_idx=0; rd_ch=0.
    - DEL_CODE -> CLEAR.
    - adc_valid is ignored.
    - arm sets cmd_err.
  - SEND: three sub-steps per word.
    - RD: drive address.
    - LAT: RAM output becomes valid.
    - OUT: register data_out and assert data_valid, data_ch and data_last.
    - Order is sample-interleaved: for idx 0..len-1, ch 0..CH-1.
    - A word is accepted on data_valid && data_ready. The next word's data_valid rises exactly 3 cycles after acceptance, so data_valid is low for 2 cycles between words.
    - data_last is high only with idx==len-1 and ch==CH-1.
    - After the last word is accepted -> FULL; save_over stays 1. Repeated READs return identical data.
    - DEL_CODE during SEND aborts: data_valid=0 next cycle -> CLEAR.
    - RD_CODE during SEND sets cmd_err.
  - CLEAR:
    - Writes 0 to address 0..DEPTH-1 of all channels, one address per cycle (DEPTH cycles). Then -> IDLE.
    - save_over=0 and cmd_err=0 on entry.
    - All commands and arm are ignored without setting cmd_err.
- Unknown command words are ignored in every state without setting cmd_err.
- Simultaneous arm and cmd_valid in IDLE: arm wins; the command is dropped.
- Counters: no wrap in CAPTURE, since len ≤ DEPTH. When len==DEPTH, wr_idx reaches DEPTH-1, which is the final write.

Test Plan:
- CH=2, DEPTH=16, len=4. Arm, then 4 adc_valid with ch0=0x0011..0x0014 and ch1=0x0021..0x0024 -> save_over rises 1 cycle after the 4th write; busy goes 1 then 0.
- From FULL, send RD_CODE with data_ready=1 -> 8 words in order 0x11,0x21,0x12,0x22,...,0x24. data_ch alternates 0,1. data_last only on 0x24. data_valid gaps are exactly 2 cycles. Return to FULL.
- Same readout with data_ready held low for 5 cycles on word 3 -> data_out and data_valid are stable; no word lost or duplicated. A second READ returns identical data.
- DEL_CODE issued mid-SEND after 3 words -> data_valid=0 next cycle; busy for 16 cycles; save_over=0. A subsequent capture with len=1 followed by READ reads 2 words; unwritten addresses read 0.
- frame_len=0 -> captures 16 samples (DEPTH). RD_CODE in IDLE and arm during CAPTURE -> cmd_err=1, capture unaffected. cmd_err cleared by DELETE.
- Reset asserted mid-CAPTURE after 2 samples -> next cycle is IDLE; save_over=0; data_valid=0; a new arm restarts at wr_idx=0.
